// File: rtl/mesh_sort_pkg.sv
// Shared types and the latency helper for the mesh shearsort engine.
// MESH_SORT_ROWMAJOR_EN adds one all-ascending row phase, which turns the snake result into row-major order.
package mesh_sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        ASC  = 1'b0,
        DESC = 1'b1
    } dir_t;

    // Clock edges from the accepting edge to the edge that raises out_valid.
    function automatic int sort_latency(input int n);
        int logn;
        logn = $clog2(n);
`ifdef MESH_SORT_ROWMAJOR_EN
        return (2 * logn + 2) * n;
`else
        return (2 * logn + 1) * n;
`endif
    endfunction

endpackage

// File: rtl/mesh_cas.sv
// Combinational compare-and-swap cell; lo/hi are the keys for the lower and higher mesh index of the pair.
module mesh_cas
    import mesh_sort_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  dir_t             dir,
    input  logic             en,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    // Strict compare only, so equal keys stay put.
    assign swapped = en && ((dir == ASC) ? (a > b) : (a < b));
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/mesh_shearsort_engine.sv
// Handshaked shearsort engine: one N x N matrix in, snake-ordered matrix out.
// MESH_SORT_ROWMAJOR_EN enables the FIX phase so the result comes out row-major sorted.
module mesh_shearsort_engine
    import mesh_sort_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*N*WIDTH-1:0]     matrix_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*N*WIDTH-1:0]     sorted_matrix,
    output logic                     busy
);

    // state | meaning
    // IDLE  | waiting for a matrix, in_ready high
    // ROW   | odd-even steps across all rows, even rows ascending, odd rows descending
    // COL   | odd-even steps down all columns, ascending
    // FIX   | final odd-even steps across all rows, all ascending (row-major build only)
    // DONE  | result presented, held until out_ready

    localparam int LOGN = $clog2(N);
    localparam int PW   = LOGN + 1;
    localparam logic [LOGN-1:0] LAST_STEP  = LOGN'(N - 1);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(LOGN);

    typedef logic [WIDTH-1:0] key_t;

    state_t          state;
    logic [LOGN-1:0] step;
    logic [PW-1:0]   phase;
    key_t            mesh      [N][N];
    key_t            next_mesh [N][N];

    logic row_act;
    logic col_act;
    logic accept;
    logic last_step;
    logic any_swap;
    dir_t row_dir [N];

    key_t row_lo [N][N-1];
    key_t row_hi [N][N-1];
    logic row_sw [N][N-1];
    key_t col_lo [N-1][N];
    key_t col_hi [N-1][N];
    logic col_sw [N-1][N];

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign row_act   = (state == ROW) || (state == FIX);
    assign col_act   = (state == COL);
    assign last_step = (step == LAST_STEP);

    always_comb begin
        for (int r = 0; r < N; r++) begin
            row_dir[r] = (((r % 2) == 1) && (state == ROW)) ? DESC : ASC;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar k = 0; k < N - 1; k++) begin : g_pair
            localparam logic PAR = 1'(k % 2);
            mesh_cas #(.WIDTH(WIDTH)) u_cas (
                .a       (mesh[r][k]),
                .b       (mesh[r][k+1]),
                .dir     (row_dir[r]),
                .en      (row_act && (step[0] == PAR)),
                .lo      (row_lo[r][k]),
                .hi      (row_hi[r][k]),
                .swapped (row_sw[r][k])
            );
        end
    end

    for (genvar k = 0; k < N - 1; k++) begin : g_col
        for (genvar c = 0; c < N; c++) begin : g_pair
            localparam logic PAR = 1'(k % 2);
            mesh_cas #(.WIDTH(WIDTH)) u_cas (
                .a       (mesh[k][c]),
                .b       (mesh[k+1][c]),
                .dir     (ASC),
                .en      (col_act && (step[0] == PAR)),
                .lo      (col_lo[k][c]),
                .hi      (col_hi[k][c]),
                .swapped (col_sw[k][c])
            );
        end
    end

    // Pairs of one step are disjoint, so only the cells of the active parity write back.
    always_comb begin
        next_mesh = mesh;
        any_swap  = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N - 1; k++) begin
                any_swap = any_swap | row_sw[r][k] | col_sw[k][r];
                if (row_act && ((k % 2) == int'(step[0]))) begin
                    next_mesh[r][k]   = row_lo[r][k];
                    next_mesh[r][k+1] = row_hi[r][k];
                end
                if (col_act && ((k % 2) == int'(step[0]))) begin
                    next_mesh[k][r]   = col_lo[k][r];
                    next_mesh[k+1][r] = col_hi[k][r];
                end
            end
        end
    end

    always_comb begin
        sorted_matrix = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sorted_matrix[(r*N+c)*WIDTH +: WIDTH] = mesh[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mesh[r][c] <= '0;
                end
            end
        end else if (accept) begin
            // Reached from IDLE or from DONE with the output handshake on the same edge.
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mesh[r][c] <= matrix_in[(r*N+c)*WIDTH +: WIDTH];
                end
            end
            step      <= '0;
            phase     <= '0;
            state     <= ROW;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ROW: begin
                    mesh <= next_mesh;
                    step <= step + 1'b1;
                    if (last_step) begin
                        if (phase == LAST_PHASE) begin
`ifdef MESH_SORT_ROWMAJOR_EN
                            state <= FIX;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
`endif
                        end else begin
                            state <= COL;
                        end
                    end
                end
                COL: begin
                    mesh <= next_mesh;
                    step <= step + 1'b1;
                    if (last_step) begin
                        phase <= phase + 1'b1;
                        state <= ROW;
                    end
                end
`ifdef MESH_SORT_ROWMAJOR_EN
                FIX: begin
                    mesh <= next_mesh;
                    step <= step + 1'b1;
                    if (last_step) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    int   lat_cnt;
    logic out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt     <= 0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid;
            if (accept) begin
                lat_cnt <= 0;
            end else if (busy) begin
                lat_cnt <= lat_cnt + 1;
            end
            if (out_valid && !out_valid_q) begin
                a_latency: assert (lat_cnt == sort_latency(N));
            end
        end
    end
`endif

endmodule

// File: tb/tb_mesh_shearsort_engine.sv
// Directed bench for mesh_shearsort_engine: table of matrices plus handshake, backpressure and reset sequences.
module tb_mesh_shearsort_engine;

`ifdef MESH_SORT_ROWMAJOR_EN
    localparam int N   = 8;
    localparam int LAT = 64;
`else
    localparam int N   = 4;
    localparam int LAT = 20;
`endif
    localparam int W  = 8;
    localparam int NK = N * N;
    localparam int M  = NK * W;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] matrix_in;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] sorted_matrix;
    logic         busy;

    int n_pass    = 0;
    int n_total   = 0;
    int swap_hits = 0;

    always #5 clk = ~clk;

    mesh_shearsort_engine #(.N(N), .WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .matrix_in     (matrix_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sorted_matrix (sorted_matrix),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (dut.any_swap) swap_hits++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [M-1:0] pack(input int k [NK]);
        logic [M-1:0] v;
        v = '0;
        for (int i = 0; i < NK; i++) v[i*W +: W] = W'(k[i]);
        return v;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 4 * LAT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic sort_one(input logic [M-1:0] mi, input logic [M-1:0] exp, input string name);
        int cyc;
        matrix_in = mi;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 1000) begin
            tick();
            cyc++;
        end
        tick();
        in_valid = 1'b0;
        wait_done(cyc);
        check({name, " latency"}, M'(cyc), M'(LAT));
        check({name, " result"}, sorted_matrix, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " release {out_valid,busy,in_ready}"}, M'({out_valid, busy, in_ready}), M'(3'b001));
    endtask

    task automatic check_reset_state(input string name);
        check({name, " {out_valid,busy,in_ready}"}, M'({out_valid, busy, in_ready}), M'(3'b001));
        check({name, " sorted_matrix"}, sorted_matrix, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

`ifndef MESH_SORT_ROWMAJOR_EN
    typedef struct {
        string name;
        int    in_k  [NK];
        int    exp_k [NK];
        bit    no_swap;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;

        vecs[0].name = "desc";
        vecs[0].in_k  = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        vecs[0].exp_k = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};
        vecs[0].no_swap = 1'b0;
        vecs[1].name = "asc";
        vecs[1].in_k  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        vecs[1].exp_k = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};
        vecs[1].no_swap = 1'b0;
        vecs[2].name = "all_5a";
        vecs[2].in_k  = '{90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90};
        vecs[2].exp_k = '{90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90, 90};
        vecs[2].no_swap = 1'b1;
        vecs[3].name = "dups";
        vecs[3].in_k  = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0};
        vecs[3].exp_k = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
        vecs[3].no_swap = 1'b0;
        vecs[4].name = "extremes";
        vecs[4].in_k  = '{255, 0, 255, 0, 0, 255, 0, 255, 255, 0, 255, 0, 0, 255, 0, 255};
        vecs[4].exp_k = '{0, 0, 0, 0, 0, 0, 0, 0, 255, 255, 255, 255, 255, 255, 255, 255};
        vecs[4].no_swap = 1'b0;
        vecs[5].name = "high";
        vecs[5].in_k  = '{240, 241, 242, 243, 244, 245, 246, 247, 248, 249, 250, 251, 252, 253, 254, 255};
        vecs[5].exp_k = '{240, 241, 242, 243, 247, 246, 245, 244, 248, 249, 250, 251, 255, 254, 253, 252};
        vecs[5].no_swap = 1'b0;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; matrix_in = '0;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            swap_hits = 0;
            sort_one(pack(vecs[i].in_k), pack(vecs[i].exp_k), vecs[i].name);
            check({vecs[i].name, " no-swap flag"}, M'(swap_hits == 0), M'(vecs[i].no_swap));
        end

        // Back-to-back: the output handshake edge also accepts the next matrix.
        matrix_in = pack(vecs[0].in_k); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(cyc);
        check("b2b first latency", M'(cyc), M'(LAT));
        check("b2b first result", sorted_matrix, pack(vecs[0].exp_k));
        matrix_in = pack(vecs[3].in_k); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b in_ready in DONE", M'(in_ready), M'(1));
        tick();
        out_ready = 1'b0;
        check("b2b recapture {out_valid,busy,in_ready}", M'({out_valid, busy, in_ready}), M'(3'b010));
        // Keep offering a different matrix while busy; it must be ignored.
        matrix_in = pack(vecs[4].in_k);
        wait_done(cyc);
        check("b2b second latency", M'(cyc), M'(LAT));
        check("b2b second result", sorted_matrix, pack(vecs[3].exp_k));

        for (int i = 0; i < 10; i++) begin
            tick();
            check("backpressure {out_valid,in_ready}", M'({out_valid, in_ready}), M'(2'b10));
            check("backpressure hold", sorted_matrix, pack(vecs[3].exp_k));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("backpressure release {out_valid,busy,in_ready}", M'({out_valid, busy, in_ready}), M'(3'b001));
        check("backpressure ignored input", sorted_matrix, pack(vecs[3].exp_k));

        // Reset part-way through a sort abandons it.
        matrix_in = pack(vecs[5].in_k); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid-sort busy", M'(busy), M'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid-sort reset");
        repeat (LAT) tick();
        check("post-reset no output", M'(out_valid), M'(0));
        sort_one(pack(vecs[0].in_k), pack(vecs[0].exp_k), "post-reset desc");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
`else
    initial begin
        int keys [NK];
        int ref_k [NK];
        int t;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; matrix_in = '0;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        void'($urandom(1));
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NK; i++) begin
                keys[i]  = int'($urandom_range(0, 255));
                ref_k[i] = keys[i];
            end
            for (int i = 0; i < NK - 1; i++) begin
                for (int j = 0; j < NK - 1 - i; j++) begin
                    if (ref_k[j] > ref_k[j+1]) begin
                        t = ref_k[j]; ref_k[j] = ref_k[j+1]; ref_k[j+1] = t;
                    end
                end
            end
            sort_one(pack(keys), pack(ref_k), "rowmajor");
            for (int i = 0; i < NK - 1; i++) begin
                check("rowmajor nondecreasing",
                      M'(sorted_matrix[i*W +: W] <= sorted_matrix[(i+1)*W +: W]), M'(1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
`endif

endmodule
